seq_restoring_divider: RTL and testbench

SEQ_RESTORING_DIVIDER -- requirements
Module: seq_restoring_divider

---
 rtl/seq_restoring_divider.sv | 120 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - unsigned multi-cycle restoring divider, one quotient bit per clock
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH:0]     r_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   d_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   rem_q;
  logic               dbz_q;
  logic               busy_q;
  logic               done_q;

  logic [2*WIDTH:0]   rq_shift;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     r_d;
  logic [WIDTH-1:0]   q_d;

  // One restoring step: shift {R,Q} left, trial-subtract the divisor, keep R on borrow
  always_comb begin
    rq_shift = {r_q, q_q} << 1;
    trial    = rq_shift[2*WIDTH:WIDTH] - {1'b0, d_q};
    r_d      = rq_shift[2*WIDTH:WIDTH];
    q_d      = rq_shift[WIDTH-1:0];
    if (!trial[WIDTH]) begin
      r_d = trial;
      q_d = rq_shift[WIDTH-1:0] | WIDTH'(1);
    end
  end

  // Control FSM, datapath and registered result/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (divisor != '0) begin
              q_q     <= dividend;
              d_q     <= divisor;
              r_q     <= '0;
              cnt_q   <= '0;
              state_q <= CALC;
            end else begin
              // Zero divisor skips the iterations and completes immediately
              quot_q  <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            quot_q  <= q_d;
            rem_q   <= r_d[WIDTH-1:0];
            dbz_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks;
  int n_fail;
  int done_cnt;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    int dvd;
    int dvs;
    int q;
    int r;
    int dbz;
    int lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Full transaction: drive start, scramble operands afterwards, time done, check results
  task automatic run_op(input int dvd, input int dvs, input int eq, input int er,
                        input int edbz, input int elat, input string tag);
    int cyc;
    int pq, pr, pz;
    int held;
    pq = int'(quotient); pr = int'(remainder); pz = int'(div_by_zero);
    held = 1;
    start = 1'b1; dividend = W'(dvd); divisor = W'(dvs);
    @(posedge clk); #1;
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (int'(quotient) != pq || int'(remainder) != pr || int'(div_by_zero) != pz) held = 0;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, cyc, elat);
    chk({tag, " results held"}, held, 1);
    chk({tag, " quotient"}, int'(quotient), eq);
    chk({tag, " remainder"}, int'(remainder), er);
    chk({tag, " div_by_zero"}, int'(div_by_zero), edbz);
    chk({tag, " busy in done"}, int'(busy), 1);
    @(posedge clk); #1;
    chk({tag, " done one cycle"}, int'(done), 0);
    chk({tag, " idle after done"}, int'(busy), 0);
  endtask

  initial begin
    int d0, cyc, dvd, dvs, eq, er;
    n_checks = 0; n_fail = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;

    // Reset values, before any clock edge
    #3;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset quotient", int'(quotient), 0);
    chk("reset remainder", int'(remainder), 0);
    chk("reset div_by_zero", int'(div_by_zero), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    vecs[0] = '{100, 7, 14, 2, 0, 8};
    vecs[1] = '{255, 1, 255, 0, 0, 8};
    vecs[2] = '{5, 9, 0, 5, 0, 8};
    vecs[3] = '{37, 0, 255, 37, 1, 0};
    vecs[4] = '{0, 5, 0, 0, 0, 8};
    vecs[5] = '{255, 255, 1, 0, 0, 8};
    vecs[6] = '{254, 255, 0, 254, 0, 8};
    vecs[7] = '{0, 0, 255, 0, 1, 0};
    vecs[8] = '{128, 2, 64, 0, 0, 8};
    vecs[9] = '{255, 16, 15, 15, 0, 8};
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat,
             $sformatf("vec%0d", i));

    // Second start during CALC is ignored
    d0 = done_cnt;
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; dividend = 8'd50; divisor = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 3;
    while (done !== 1'b1 && cyc < 25) begin @(posedge clk); #1; cyc++; end
    chk("ignored start latency", cyc, 8);
    chk("ignored start quotient", int'(quotient), 14);
    chk("ignored start remainder", int'(remainder), 2);
    repeat (12) @(posedge clk);
    #1;
    chk("ignored start done pulses", done_cnt - d0, 1);
    chk("ignored start idle", int'(busy), 0);

    // Reset mid-CALC aborts with no done pulse
    d0 = done_cnt;
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort quotient", int'(quotient), 0);
    chk("abort remainder", int'(remainder), 0);
    chk("abort div_by_zero", int'(div_by_zero), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort no done pulse", done_cnt - d0, 0);
    run_op(200, 3, 66, 2, 0, 8, "after abort");

    // start held high: back-to-back operations with one IDLE cycle between
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    cyc = 0;
    while (done !== 1'b1 && cyc < 25) begin @(posedge clk); #1; cyc++; end
    chk("b2b first done seen", int'(done), 1);
    @(posedge clk); #1;
    cyc = 1;
    while (done !== 1'b1 && cyc < 25) begin @(posedge clk); #1; cyc++; end
    start = 1'b0;
    chk("b2b done spacing", cyc, W + 2);
    chk("b2b quotient", int'(quotient), 14);
    chk("b2b remainder", int'(remainder), 2);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b idle", int'(busy), 0);

    // Random operands against arithmetic reference
    for (int i = 0; i < 3000; i++) begin
      dvd = int'($urandom_range(0, 255));
      dvs = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, 255));
      if (dvs == 0) begin eq = 255; er = dvd; end
      else begin eq = dvd / dvs; er = dvd % dvs; end
      run_op(dvd, dvs, eq, er, (dvs == 0) ? 1 : 0, (dvs == 0) ? 0 : W,
             $sformatf("rand %0d/%0d", dvd, dvs));
      if (dvs != 0) begin
        chk($sformatf("rand identity %0d/%0d", dvd, dvs),
            int'(quotient) * dvs + int'(remainder), dvd);
        chk($sformatf("rand rem bound %0d/%0d", dvd, dvs),
            (int'(remainder) < dvs) ? 1 : 0, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
